// File: rtl/seq_loop_pkg.sv
// Shared types for the sequential-loop cosim monitor.
// Monitor FSM states and sticky error bit positions.
package seq_loop_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } mon_state_e;

    localparam int ERR_NO_ENTRY = 0;
    localparam int ERR_FIN_LOOP = 1;
    localparam int ERR_SAT      = 2;
    localparam int ERR_W        = 3;

endpackage

// File: rtl/seq_loop_monitor_if.sv
// Signal bundle between the bench/kernel side and the loop monitor.
// master drives state bus and config; slave is the monitor itself.
interface seq_loop_monitor_if #(
    parameter int FSM_WIDTH  = 2,
    parameter int N_PRE      = 1,
    parameter int N_POST     = 2,
    parameter int N_QUIT     = 1,
    parameter int N_ITER_END = 1,
    parameter int CNT_WIDTH  = 32
);
    logic [FSM_WIDTH-1:0]            cur_state;
    logic [N_PRE*FSM_WIDTH-1:0]      pre_states;
    logic [N_PRE-1:0]                pre_valid;
    logic [N_POST*FSM_WIDTH-1:0]     post_states;
    logic [N_POST-1:0]               post_valid;
    logic [N_QUIT*FSM_WIDTH-1:0]     quit_states;
    logic [N_QUIT-1:0]               quit_valid;
    logic [N_ITER_END*FSM_WIDTH-1:0] iter_end_states;
    logic [N_ITER_END-1:0]           iter_end_valid;
    logic [FSM_WIDTH-1:0]            iter_start_state;
    logic                            one_state_loop;
    logic                            finish;
    logic                            loop_active;
    logic                            iter_done;
    logic                            loop_exit;
    logic [CNT_WIDTH-1:0]            iter_count;
    logic [CNT_WIDTH-1:0]            last_trip;
    logic [CNT_WIDTH-1:0]            trip_count;
    logic [2:0]                      err;

    modport master (
        output cur_state, pre_states, pre_valid, post_states, post_valid,
        output quit_states, quit_valid, iter_end_states, iter_end_valid,
        output iter_start_state, one_state_loop, finish,
        input  loop_active, iter_done, loop_exit,
        input  iter_count, last_trip, trip_count, err
    );

    modport slave (
        input  cur_state, pre_states, pre_valid, post_states, post_valid,
        input  quit_states, quit_valid, iter_end_states, iter_end_valid,
        input  iter_start_state, one_state_loop, finish,
        output loop_active, iter_done, loop_exit,
        output iter_count, last_trip, trip_count, err
    );

endinterface

// File: rtl/seq_state_match.sv
// Packed state-list matcher: hit when any enabled entry equals i_state.
// An all-disabled list never matches.
module seq_state_match #(
    parameter int FSM_WIDTH = 2,
    parameter int N         = 1
) (
    input  logic [N*FSM_WIDTH-1:0] i_states,
    input  logic [N-1:0]           i_valid,
    input  logic [FSM_WIDTH-1:0]   i_state,
    output logic                   o_hit
);

    // OR-reduce the per-entry equality, gated by the entry enable
    always_comb begin
        o_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_valid[i] && (i_states[i*FSM_WIDTH +: FSM_WIDTH] == i_state)) begin
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_loop_monitor.sv
// Cosim monitor tracking one sequential loop of an HLS kernel FSM.
// Detects entry/back-edge/exit, counts iterations and trips, flags errors.
module seq_loop_monitor
    import seq_loop_pkg::*;
#(
    parameter int FSM_WIDTH  = 2,
    parameter int N_PRE      = 1,
    parameter int N_POST     = 2,
    parameter int N_QUIT     = 1,
    parameter int N_ITER_END = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic               clock,
    input  logic               reset,
    seq_loop_monitor_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    mon_state_e               r_state;
    mon_state_e               w_state_nxt;
    logic [FSM_WIDTH-1:0]     r_prev_state;
    logic                     r_prev_vld;
    logic                     r_loop_active;
    logic                     r_iter_done;
    logic                     w_iter_done_nxt;
    logic                     r_loop_exit;
    logic                     w_loop_exit_nxt;
    logic [CNT_WIDTH-1:0]     r_iter_count;
    logic [CNT_WIDTH-1:0]     w_iter_count_nxt;
    logic [CNT_WIDTH-1:0]     r_last_trip;
    logic [CNT_WIDTH-1:0]     w_last_trip_nxt;
    logic [CNT_WIDTH-1:0]     r_trip_count;
    logic [CNT_WIDTH-1:0]     w_trip_count_nxt;
    logic [ERR_W-1:0]         r_err;
    logic [ERR_W-1:0]         w_err_nxt;

    logic [FSM_WIDTH-1:0]     w_cur;
    logic                     w_pre_prev;
    logic                     w_quit_prev;
    logic                     w_iter_end_prev;
    logic                     w_post_cur;
    logic                     w_unused_post_prev;
    logic                     w_cur_is_start;
    logic                     w_prev_is_start;
    logic                     w_entry;
    logic                     w_idle_exit;
    logic                     w_exit;
    logic                     w_back;
    logic                     w_iter_max;
    logic                     w_trip_max;

    assign w_cur = bus.cur_state;

    seq_state_match #(.FSM_WIDTH(FSM_WIDTH), .N(N_PRE)) u_pre_prev (
        .i_states (bus.pre_states),
        .i_valid  (bus.pre_valid),
        .i_state  (r_prev_state),
        .o_hit    (w_pre_prev)
    );

    seq_state_match #(.FSM_WIDTH(FSM_WIDTH), .N(N_QUIT)) u_quit_prev (
        .i_states (bus.quit_states),
        .i_valid  (bus.quit_valid),
        .i_state  (r_prev_state),
        .o_hit    (w_quit_prev)
    );

    seq_state_match #(.FSM_WIDTH(FSM_WIDTH), .N(N_ITER_END)) u_iter_end_prev (
        .i_states (bus.iter_end_states),
        .i_valid  (bus.iter_end_valid),
        .i_state  (r_prev_state),
        .o_hit    (w_iter_end_prev)
    );

    seq_state_match #(.FSM_WIDTH(FSM_WIDTH), .N(N_POST)) u_post_cur (
        .i_states (bus.post_states),
        .i_valid  (bus.post_valid),
        .i_state  (w_cur),
        .o_hit    (w_post_cur)
    );

    // Spare post(prev) matcher, kept for a future exit qualifier
    seq_state_match #(.FSM_WIDTH(FSM_WIDTH), .N(N_POST)) u_post_prev (
        .i_states (bus.post_states),
        .i_valid  (bus.post_valid),
        .i_state  (r_prev_state),
        .o_hit    (w_unused_post_prev)
    );

    assign w_cur_is_start  = (w_cur == bus.iter_start_state);
    assign w_prev_is_start = (r_prev_state == bus.iter_start_state);
    assign w_entry     = r_prev_vld && w_pre_prev && w_cur_is_start;
    assign w_idle_exit = r_prev_vld && w_quit_prev && w_post_cur;
    assign w_exit      = r_prev_vld && (w_quit_prev || w_iter_end_prev) && w_post_cur;
    assign w_back      = r_prev_vld &&
                         ((w_iter_end_prev && w_cur_is_start) ||
                          (bus.one_state_loop && w_prev_is_start && w_cur_is_start));
    assign w_iter_max  = (r_iter_count == CNT_MAX);
    assign w_trip_max  = (r_trip_count == CNT_MAX);

    // Monitor FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, pulses, counters and error bits; exit beats back-edge
    always_comb begin
        w_state_nxt      = r_state;
        w_iter_done_nxt  = 1'b0;
        w_loop_exit_nxt  = 1'b0;
        w_iter_count_nxt = r_iter_count;
        w_last_trip_nxt  = r_last_trip;
        w_trip_count_nxt = r_trip_count;
        w_err_nxt        = r_err;
        unique case (r_state)
            IDLE: begin
                if (w_idle_exit) begin
                    w_err_nxt[ERR_NO_ENTRY] = 1'b1;
                end
                if (bus.finish) begin
                    w_state_nxt = DONE;
                end else if (w_entry) begin
                    w_state_nxt      = ACTIVE;
                    w_iter_count_nxt = '0;
                end
            end
            ACTIVE: begin
                if (w_exit) begin
                    w_iter_done_nxt  = 1'b1;
                    w_loop_exit_nxt  = 1'b1;
                    w_iter_count_nxt = '0;
                    w_state_nxt      = bus.finish ? DONE : IDLE;
                    if (w_iter_max) begin
                        w_last_trip_nxt    = CNT_MAX;
                        w_err_nxt[ERR_SAT] = 1'b1;
                    end else begin
                        w_last_trip_nxt = r_iter_count + CNT_ONE;
                    end
                    if (w_trip_max) begin
                        w_err_nxt[ERR_SAT] = 1'b1;
                    end else begin
                        w_trip_count_nxt = r_trip_count + CNT_ONE;
                    end
                end else if (bus.finish) begin
                    w_err_nxt[ERR_FIN_LOOP] = 1'b1;
                    w_state_nxt             = DONE;
                end else if (w_back) begin
                    w_iter_done_nxt = 1'b1;
                    if (w_iter_max) begin
                        w_err_nxt[ERR_SAT] = 1'b1;
                    end else begin
                        w_iter_count_nxt = r_iter_count + CNT_ONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs, counters and the previous-state sample
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_state  <= '0;
            r_prev_vld    <= 1'b0;
            r_loop_active <= 1'b0;
            r_iter_done   <= 1'b0;
            r_loop_exit   <= 1'b0;
            r_iter_count  <= '0;
            r_last_trip   <= '0;
            r_trip_count  <= '0;
            r_err         <= '0;
        end else begin
            r_prev_state  <= w_cur;
            r_prev_vld    <= 1'b1;
            r_loop_active <= (w_state_nxt == ACTIVE);
            r_iter_done   <= w_iter_done_nxt;
            r_loop_exit   <= w_loop_exit_nxt;
            r_iter_count  <= w_iter_count_nxt;
            r_last_trip   <= w_last_trip_nxt;
            r_trip_count  <= w_trip_count_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign bus.loop_active = r_loop_active;
    assign bus.iter_done   = r_iter_done;
    assign bus.loop_exit   = r_loop_exit;
    assign bus.iter_count  = r_iter_count;
    assign bus.last_trip   = r_last_trip;
    assign bus.trip_count  = r_trip_count;
    assign bus.err         = r_err;

endmodule
